// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer. It drives one shared NBIT adder one word per
// cycle, from the least significant word to the most significant, and chains the carry
// through a register.
module mp_add_seq #(
    parameter int unsigned NBIT   = 16,
    parameter int unsigned NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic                     ci,
    input  logic [NBIT*NWORDS-1:0]   a,
    input  logic [NBIT*NWORDS-1:0]   b,
    output logic [NBIT-1:0]          add_in1,
    output logic [NBIT-1:0]          add_in2,
    output logic                     add_c_in,
    input  logic [NBIT-1:0]          add_res,
    input  logic                     add_c_out,
    output logic                     busy,
    output logic                     done,
    output logic [NBIT*NWORDS-1:0]   sum,
    output logic                     co,
    output logic                     ovf
);

    localparam int unsigned IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned LAST = NWORDS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state;
    logic [NWORDS-1:0][NBIT-1:0]   a_q;
    logic [NWORDS-1:0][NBIT-1:0]   b_q;
    logic [NWORDS-1:0][NBIT-1:0]   sum_q;
    logic [IW-1:0]                 idx;
    logic                          carry_q;

    // Adder operands come straight from the latched word slices and the carry register.
    assign add_in1  = a_q[idx];
    assign add_in2  = b_q[idx];
    assign add_c_in = carry_q;
    assign sum      = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so the inversion and the forced carry happen at latch time.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | ci;
                        idx     <= '0;
                        sum_q   <= '0;
                        co      <= 1'b0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[idx] <= add_res;
                    carry_q    <= add_c_out;
                    if (idx == IW'(LAST)) begin
                        co    <= add_c_out;
                        ovf   <= (a_q[LAST][NBIT-1] == b_q[LAST][NBIT-1]) &&
                                 (add_res[NBIT-1] != a_q[LAST][NBIT-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
